vote_window_collector: RTL and testbench
========================================

Name: vote_window_collector

Overview:
- Upstream feeder for the combinational majority voter.
- Collects a serial stream of 1-bit samples, under a valid/ready handshake, into non-overlapping N-bit windows.
- Presents each completed window as a registered N-bit word, with valid/ready backpressure, to the voter's data input.
- Also counts emitted windows for debug and status.

Parameters:
- N, 5, window size in bits (must be >= 2); matches the voter's bit-size parameter.
- MAJORITY, 3, vote threshold; used only when VOTE_REG_EN is defined.
- CNT_W, 16, width of the emitted-window counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset.
- flush  input  1  synchronous clear of the partial or held window.
- in_bit  input  1  serial sample.
- in_valid  input  1  in_bit is valid.
- in_ready  output  1  block accepts a sample this cycle.
- out_data  output  N  completed window; the first accepted sample is at bit 0.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream consumes the window.
- win_cnt  output  CNT_W  number of windows handed off; wraps modulo 2^CNT_W.
- vote  output  1  registered majority of out_data (see Optional Feature).

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-low: rst_n is sampled on the rising edge of clk.
- Reset values:
  - state=FILL, fill count=0, out_data=0, out_valid=0, win_cnt=0, vote=0.
  - in_ready=1 from the first cycle after reset.
  - A reset asserted mid-FILL or mid-HOLD discards all data. No handshake completes in a reset cycle.
- Fill count:
  - Width is clog2(N), counting 0..N-1.
- States:
  - FILL: gathering samples.
  - HOLD: window presented downstream.
- FILL behaviour:
  - in_ready=1 and out_valid=0.
  - Accept occurs when in_valid=1. On accept, the window shifts right with in_bit entering at bit N-1: window <= {in_bit, window[N-1:1]}. The fill count increments.
  - When the accepted sample is the Nth (count==N-1), the shifted window loads into out_data, count goes to 0, and state goes to HOLD.
- Latency: out_valid is 1 in the cycle after the Nth sample is accepted.
- HOLD behaviour:
  - out_valid=1; out_data is stable until the handshake.
  - in_ready=out_ready, so the block forwards no bubble.
- Output handshake (out_valid & out_ready):
  - win_cnt increments, wrapping from all-ones to 0.
  - If in_valid=1 in the same cycle, that sample is accepted as sample 0 of the next window: state=FILL, count=1.
  - Otherwise state=FILL, count=0.
- out_valid deasserts on the cycle after the handshake.
- Backpressure: out_ready=0 in HOLD holds out_data and out_valid indefinitely, and in_ready=0.
- flush:
  - Has priority over every other event except reset.
  - Effects: count=0, state=FILL, out_valid=0.
  - The sample offered in the flush cycle is not accepted (in_ready=0 while flush=1).
  - A window held in HOLD is dropped, and win_cnt does not increment.
  - out_data keeps its old value.
- in_ready is combinational from state, out_ready and flush only; there is no path from in_valid.
- out_valid, out_data, win_cnt and vote are all registered.

Optional Feature:
- Macro: VOTE_REG_EN.
- Defined:
  - vote is registered together with out_data on the Nth accept.
  - vote = (popcount(shifted window) >= MAJORITY).
  - It is valid in the same cycle as out_valid, with zero extra latency.
  - vote holds with out_data and is cleared by reset.
  - It is not cleared by flush.
- Undefined:
  - vote is tied to 0.
  - No popcount logic is synthesized, and MAJORITY is ignored.

Decomposition:
- Shared package vote_pkg:
  - State encodings FILL=1'b0 and HOLD=1'b1.
  - A clog2 function for fill-count width.
  - Popcount function for N-bit vectors, shared with the majority voter.
- One natural sub-module, vote_popcount: combinational popcount and threshold compare, instantiated only under VOTE_REG_EN.
- All control, shift register and counter logic stays in the top module.

Test Plan:
- Basic window:
  - Stimulus: N=5, in_valid held 1, samples 1,0,1,1,0.
  - Response: out_data=5'b01101 with out_valid=1 one cycle after the 5th accept; vote=1 with VOTE_REG_EN, 0 without.
- Backpressure:
  - Stimulus: complete a window, hold out_ready=0 for 10 cycles, then assert out_ready=1.
  - Response: out_data stable; in_ready=0 throughout; win_cnt 0->1 on the handshake only.
- Back-to-back:
  - Stimulus: out_ready=1 and in_valid=1 continuously, samples 11100 then 00011.
  - Response: windows 5'b00111 then 5'b11000 with no bubble; vote 1 then 0; win_cnt=2.
- Flush:
  - Stimulus: flush after 3 samples, then 5 more samples 0,0,0,0,1.
  - Response: out_data=5'b10000; the flushed samples never appear.
- Flush in HOLD and reset:
  - Flush in HOLD drops the window: out_valid=0 next cycle, win_cnt unchanged.
  - rst_n=0 mid-fill clears count, out_valid and win_cnt.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 windows emitted.
  - Response: win_cnt reads 15 after 15 windows, 0 after the 16th, and 1 after the 17th.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared definitions for the majority-vote path: FSM encoding, width helper
// and the popcount used by both the window collector and the voter.
package vote_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Ceiling log2 for v >= 2; bounded loop keeps it usable at elaboration.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      c += {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational popcount of an N-bit window and comparison against a
// majority threshold. Windows wider than 32 bits are not supported.
module vote_popcount
  import vote_pkg::*;
#(
  parameter int N        = 5,
  parameter int MAJORITY = 3
) (
  input  logic [N-1:0] bits,
  output logic         maj
);

  logic [31:0] ext;

  always_comb begin
    ext         = '0;
    ext[N-1:0]  = bits;
    maj         = (int'(popcount(ext)) >= MAJORITY);
  end

endmodule

// File: rtl/vote_window_collector.sv
// Serial-to-window collector feeding the majority voter: gathers N accepted
// samples (first at bit 0) and presents them with valid/ready backpressure.
// Optional registered vote output enabled by defining VOTE_REG_EN.
module vote_window_collector
  import vote_pkg::*;
#(
  parameter int N        = 5,
  parameter int MAJORITY = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] win_cnt,
  output logic             vote
);

  localparam int CW = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state_p0;
  logic [CW-1:0]   cnt_p0;
  // Only the upper N-1 bits of the window are ever shifted back in, so bit 0
  // of the previous shift never needs to be stored.
  logic [N-2:0]    part_p0;
  logic [N-1:0]    shifted;
  logic            last_accept;

  assign shifted     = {in_bit, part_p0};
  assign in_ready    = !flush && ((state_p0 == FILL) || out_ready);
  assign last_accept = !flush && (state_p0 == FILL) && in_valid && (cnt_p0 == LAST);

  // Stage p0: accept samples, build the window, run the FILL/HOLD handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0  <= FILL;
      cnt_p0    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      win_cnt   <= '0;
    end else if (flush) begin
      state_p0  <= FILL;
      cnt_p0    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_p0)
        FILL: begin
          if (in_valid) begin
            part_p0 <= shifted[N-1:1];
            if (cnt_p0 == LAST) begin
              out_data  <= shifted;
              out_valid <= 1'b1;
              cnt_p0    <= '0;
              state_p0  <= HOLD;
            end else begin
              cnt_p0 <= cnt_p0 + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            win_cnt   <= win_cnt + CNT_W'(1);
            out_valid <= 1'b0;
            state_p0  <= FILL;
            if (in_valid) begin
              part_p0 <= shifted[N-1:1];
              cnt_p0  <= CW'(1);
            end else begin
              cnt_p0  <= '0;
            end
          end
        end
        default: state_p0 <= FILL;
      endcase
    end
  end

`ifdef VOTE_REG_EN
  logic maj;

  vote_popcount #(
    .N        (N),
    .MAJORITY (MAJORITY)
  ) u_popcount (
    .bits (shifted),
    .maj  (maj)
  );

  // Stage p0: vote captured alongside out_data; flush leaves it untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vote <= 1'b0;
    end else if (last_accept) begin
      vote <= maj;
    end
  end
`else
  assign vote = 1'b0;

  // A threshold above N could never be met; MAJORITY has no other use here.
  if (MAJORITY > N) begin : g_majority_unreachable
  end

  logic unused_last;
  assign unused_last = last_accept;
`endif

endmodule

// File: tb/tb_vote_window_collector.sv
// Directed self-checking bench for vote_window_collector (N=5, CNT_W=4).
module tb_vote_window_collector;

  localparam int N     = 5;
  localparam int CNT_W = 4;
`ifdef VOTE_REG_EN
  localparam bit VE = 1'b1;
`else
  localparam bit VE = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] win_cnt;
  logic             vote;

  int tests;
  int fails;
  int exp_cnt;

  vote_window_collector #(
    .N        (N),
    .MAJORITY (3),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .win_cnt   (win_cnt),
    .vote      (vote)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
  endtask

  initial begin
    logic [N-1:0] held;
    tests = 0;
    fails = 0;
    rst_n = 1'b0; flush = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_win_cnt", 32'(win_cnt), 32'd0);
    chk("rst_vote", 32'(vote), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // basic window 1,0,1,1,0 -> 01101
    send(1); send(0); send(1); send(1);
    chk("basic_not_yet", 32'(out_valid), 32'd0);
    send(0);
    in_valid = 1'b0;
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'b01101);
    chk("basic_vote", 32'(vote), 32'(VE & 1'b1));
    chk("basic_in_ready", 32'(in_ready), 32'd0);

    // backpressure for 10 cycles
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_bit   = i[0];
      tick();
      chk("bp_data", 32'(out_data), 32'b01101);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_win_cnt", 32'(win_cnt), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_handshake_cnt", 32'(win_cnt), 32'd1);
    chk("bp_valid_drop", 32'(out_valid), 32'd0);

    // back-to-back: 11100 then 00011, no bubble
    send(1); send(1); send(1); send(0); send(0);
    chk("b2b_w1_valid", 32'(out_valid), 32'd1);
    chk("b2b_w1_data", 32'(out_data), 32'b00111);
    chk("b2b_w1_vote", 32'(vote), 32'(VE & 1'b1));
    chk("b2b_hold_in_ready", 32'(in_ready), 32'd1);
    send(0);
    chk("b2b_cnt_after_w1", 32'(win_cnt), 32'd2);
    chk("b2b_gap_valid", 32'(out_valid), 32'd0);
    send(0); send(0); send(1);
    chk("b2b_w2_not_yet", 32'(out_valid), 32'd0);
    send(1);
    chk("b2b_w2_valid", 32'(out_valid), 32'd1);
    chk("b2b_w2_data", 32'(out_data), 32'b11000);
    chk("b2b_w2_vote", 32'(vote), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("b2b_cnt_after_w2", 32'(win_cnt), 32'd3);

    // flush after 3 samples, then 0,0,0,0,1 -> 10000
    out_ready = 1'b0;
    send(1); send(1); send(1);
    flush  = 1'b1;
    in_bit = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    send(0); send(0); send(0); send(0);
    chk("flush_count_cleared", 32'(out_valid), 32'd0);
    send(1);
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd1);
    chk("flush_data", 32'(out_data), 32'b10000);
    chk("flush_vote", 32'(vote), 32'd0);

    // flush in HOLD drops the window even with out_ready high
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("hold_flush_valid", 32'(out_valid), 32'd0);
    chk("hold_flush_cnt", 32'(win_cnt), 32'd3);
    chk("hold_flush_data_kept", 32'(out_data), 32'b10000);

    // reset mid-fill
    send(1); send(1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_cnt", 32'(win_cnt), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    send(1); send(1); send(1); send(1);
    chk("midrst_fill_cleared", 32'(out_valid), 32'd0);
    send(1);
    in_valid = 1'b0;
    chk("midrst_w_data", 32'(out_data), 32'b11111);
    chk("midrst_w_vote", 32'(vote), 32'(VE & 1'b1));

    // counter wrap: 17 windows with CNT_W=4
    exp_cnt = 0;
    held    = 5'b11111;
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) begin
        for (int b = 0; b < N; b++) send(k[b % 4]);
        in_valid = 1'b0;
        held = {k[0], k[3], k[2], k[1], k[0]};
        chk("wrap_data", 32'(out_data), 32'(held));
      end
      tick();
      exp_cnt = (exp_cnt + 1) % 16;
      if (k == 15) chk("wrap_cnt15", 32'(win_cnt), 32'd15);
      else if (k == 16) chk("wrap_cnt16", 32'(win_cnt), 32'd0);
      else if (k == 17) chk("wrap_cnt17", 32'(win_cnt), 32'd1);
      else chk("wrap_cnt", 32'(win_cnt), 32'(exp_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
